joy_serializer: RTL and testbench

- Emulates the cascaded 24-bit parallel-in/serial-out shift-register chain that sits on the joystick connector.
- Presents two 12-bit active-low pad states to a host joystick decoder, serialised in the frame order the decoder expects.
- The host drives joy_clk and joy_load from its own clock domain; this block synchronises both, loads on joy_load low, and shifts on joy_clk rising edges.
- Used in the Next-side test harness and in pad-emulation paths (USB/PS2 pad to DB9 decoder).

---
 rtl/joy_serializer.sv | 108 ++++++++++
 tb/tb_joy_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/joy_serializer.sv
// Emulates the cascaded 24-bit PISO shift-register chain on a joystick connector.
// It synchronises the host joy_clk/joy_load strobes into clk and shifts two 12-bit pads out.
module joy_serializer #(
  parameter int   SYNC_STAGES = 2,
  parameter int   TIMEOUT_W   = 16,
  parameter logic FILL_BIT    = 1'b1
) (
  input  logic        clk,
  input  logic        clock_locked,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  input  logic [11:0] joy1_i,
  input  logic [11:0] joy2_i,
  output logic        frame_done,
  output logic        host_active
);

  localparam logic [4:0] FRAME_BITS = 5'd24;

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] load_sync_reg;
  logic [SYNC_STAGES-1:0] clk_sync_next;
  logic [SYNC_STAGES-1:0] load_sync_next;
  logic                   clk_d_reg;
  logic                   load_d_reg;
  logic                   sync_clk;
  logic                   sync_load;
  logic                   clk_rise;
  logic                   load_fall;

  logic [23:0]            shreg;
  logic [23:0]            load_vec;
  logic [4:0]             bit_cnt;
  logic [TIMEOUT_W-1:0]   wd_cnt;

  assign clk_sync_next  = {clk_sync_reg[SYNC_STAGES-2:0], joy_clk};
  assign load_sync_next = {load_sync_reg[SYNC_STAGES-2:0], joy_load};
  assign sync_clk       = clk_sync_reg[SYNC_STAGES-1];
  assign sync_load      = load_sync_reg[SYNC_STAGES-1];
  assign clk_rise       = sync_clk & ~clk_d_reg;
  assign load_fall      = ~sync_load & load_d_reg;

  // Idle level of both host strobes is high, so the chain resets to 1s.
  always_ff @(posedge clk or negedge clock_locked) begin
    if (!clock_locked) begin
      clk_sync_reg  <= '1;
      load_sync_reg <= '1;
      clk_d_reg     <= 1'b1;
      load_d_reg    <= 1'b1;
    end else begin
      clk_sync_reg  <= clk_sync_next;
      load_sync_reg <= load_sync_next;
      clk_d_reg     <= sync_clk;
      load_d_reg    <= sync_load;
    end
  end

  // Frame layout as seen by the decoder, MSB shifted out first.
  assign load_vec = {
    joy1_i[8], joy1_i[6], joy1_i[5], joy1_i[4],
    joy1_i[3], joy1_i[2], joy1_i[1], joy1_i[0],
    joy2_i[8], joy2_i[6], joy2_i[5], joy2_i[4],
    joy2_i[3], joy2_i[2], joy2_i[1], joy2_i[0],
    joy2_i[10], joy2_i[11], joy2_i[9], joy2_i[7],
    joy1_i[10], joy1_i[11], joy1_i[9], joy1_i[7]
  };

  always_ff @(posedge clk or negedge clock_locked) begin
    if (!clock_locked) begin
      shreg      <= '1;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      joy_data   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      joy_data   <= shreg[23];
      if (!sync_load) begin
        // Level-sensitive load keeps the pads transparent and beats any shift.
        shreg   <= load_vec;
        bit_cnt <= '0;
      end else if (clk_rise) begin
        shreg <= {shreg[22:0], FILL_BIT};
        if (bit_cnt < FRAME_BITS) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
        if (bit_cnt == FRAME_BITS - 5'd1) begin
          frame_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clock_locked) begin
    if (!clock_locked) begin
      wd_cnt      <= '0;
      host_active <= 1'b0;
    end else if (load_fall) begin
      wd_cnt      <= '0;
      host_active <= 1'b1;
    end else if (wd_cnt != '1) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      host_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_joy_serializer.sv
// Directed bench for joy_serializer: reset state, frame contents, saturation,
// aborted frames, load/shift priority, async reset and host watchdog.
module tb_joy_serializer;

  localparam int TW = 9;

  logic        clk;
  logic        clock_locked;
  logic        joy_clk;
  logic        joy_load;
  logic        joy_data;
  logic [11:0] joy1_i;
  logic [11:0] joy2_i;
  logic        frame_done;
  logic        host_active;

  int vectors;
  int miscompares;
  int fd_count;

  joy_serializer #(
    .SYNC_STAGES(2),
    .TIMEOUT_W  (TW),
    .FILL_BIT   (1'b1)
  ) dut (
    .clk         (clk),
    .clock_locked(clock_locked),
    .joy_clk     (joy_clk),
    .joy_load    (joy_load),
    .joy_data    (joy_data),
    .joy1_i      (joy1_i),
    .joy2_i      (joy2_i),
    .frame_done  (frame_done),
    .host_active (host_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
  endtask

  task automatic host_load();
    joy_load = 1'b0;
    tick(6);
    joy_load = 1'b1;
    tick(6);
  endtask

  // clk/8 host clock: four system clocks per phase.
  task automatic host_rise();
    joy_clk = 1'b1;
    tick(4);
    joy_clk = 1'b0;
    tick(4);
  endtask

  task automatic read_bits(input string tag, input logic [23:0] exp, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      check($sformatf("%s_bit%0d", tag, i), {31'd0, joy_data}, {31'd0, exp[23-i]});
      host_rise();
    end
  endtask

  initial begin
    int fd_before;
    vectors      = 0;
    miscompares  = 0;
    fd_count     = 0;
    clock_locked = 1'b0;
    joy_clk      = 1'b0;
    joy_load     = 1'b1;
    joy1_i       = 12'hFFF;
    joy2_i       = 12'hFFF;
    tick(3);
    check("rst_data", {31'd0, joy_data}, 32'd1);
    check("rst_active", {31'd0, host_active}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    clock_locked = 1'b1;
    tick(2 ** TW + 20);
    check("idle_data", {31'd0, joy_data}, 32'd1);
    check("idle_active", {31'd0, host_active}, 32'd0);
    check("idle_fd", fd_count, 32'd0);

    // Pad 1 up pressed: eighth bit low.
    joy1_i = 12'hFFE;
    joy2_i = 12'hFFF;
    host_load();
    read_bits("up", 24'hFEFFFF, 23);
    check("up_fd_early", fd_count, 32'd0);
    host_rise();
    check("up_fd", fd_count, 32'd1);
    check("up_active", {31'd0, host_active}, 32'd1);

    // Pad 1 service and pad 2 start.
    joy1_i = 12'h7FF;
    joy2_i = 12'hEFF;
    host_load();
    read_bits("svc", 24'hFF7FFB, 24);
    check("svc_fd", fd_count, 32'd2);

    // All pressed, 30 rises: 24 zeros then fill bits.
    joy1_i = 12'h000;
    joy2_i = 12'h000;
    host_load();
    for (int i = 0; i < 30; i++) begin
      check($sformatf("sat_bit%0d", i), {31'd0, joy_data}, (i < 24) ? 32'd0 : 32'd1);
      host_rise();
    end
    check("sat_fd", fd_count, 32'd3);
    check("sat_cnt", {27'd0, dut.bit_cnt}, 32'd24);

    // Aborted frame after 10 bits, restarted with new pad values.
    joy1_i = 12'h0F0;
    joy2_i = 12'h00F;
    host_load();
    read_bits("abort", 24'h700F01, 10);
    joy1_i = 12'h5A5;
    joy2_i = 12'h3C3;
    host_load();
    check("abort_fd", fd_count, 32'd3);
    read_bits("restart", 24'hA5C339, 24);
    check("restart_fd", fd_count, 32'd4);
    check("wd_active", {31'd0, host_active}, 32'd1);
    tick(2 ** TW + 20);
    check("wd_expired", {31'd0, host_active}, 32'd0);

    // joy_clk rises while load is held low: no shift, pads transparent.
    joy1_i = 12'hEFF;
    joy2_i = 12'hFFF;
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    tick(6);
    check("coinc_start", {31'd0, joy_data}, 32'd0);
    joy1_i = 12'hFFF;
    tick(6);
    check("coinc_transp", {31'd0, joy_data}, 32'd1);
    joy1_i = 12'hEFF;
    tick(6);
    joy_load = 1'b1;
    tick(6);
    check("coinc_noshift", {31'd0, joy_data}, 32'd0);
    joy_clk = 1'b0;
    tick(4);
    host_rise();
    check("coinc_next", {31'd0, joy_data}, 32'd1);

    // Async reset mid-frame forces the output high within the cycle.
    joy1_i = 12'h000;
    joy2_i = 12'h000;
    host_load();
    host_rise();
    host_rise();
    host_rise();
    check("mid_pre", {31'd0, joy_data}, 32'd0);
    fd_before = fd_count;
    clock_locked = 1'b0;
    #1;
    check("mid_rst_data", {31'd0, joy_data}, 32'd1);
    check("mid_rst_active", {31'd0, host_active}, 32'd0);
    tick(3);
    clock_locked = 1'b1;
    tick(10);
    check("mid_noreload", {31'd0, joy_data}, 32'd1);
    host_rise();
    check("mid_fill", {31'd0, joy_data}, 32'd1);
    check("mid_fd", fd_count, fd_before);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
